// File: rtl/fetch_controller.sv
// Instruction fetch front end: drives a combinational instruction memory and
// queues {pc, instruction} pairs in a small prefetch FIFO for the consumer.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_ins,
  output logic [31:0] ins_out,
  output logic [31:0] pc_out,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted,
  output logic [31:0] fetch_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     ins_buf [DEPTH];
  logic [31:0]     pc_buf  [DEPTH];
  logic            pop;
  logic            push;

  assign imem_addr = pc;
  assign ins_valid = (count != '0);
  assign ins_out   = ins_buf[rd_ptr];
  assign pc_out    = pc_buf[rd_ptr];
  assign halted    = (state == HALT);

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign pop  = ins_valid & ins_ready;
  assign push = (state == RUN) && !redirect && !halt &&
                ((count != CW'(DEPTH)) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_count <= '0;
    end else if (redirect) begin
      // Flush wins over everything, including a pop of the head this cycle.
      state  <= RUN;
      pc     <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (state == RUN && halt)
        state <= HALT;
      if (push) begin
        pc          <= pc + 32'd1;
        wr_ptr      <= wr_ptr + 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Buffer payload carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      ins_buf[wr_ptr] <= imem_ins;
      pc_buf[wr_ptr]  <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller against a 1K-word combinational memory.
module tb_fetch_controller;
  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_ins;
  logic [31:0] ins_out;
  logic [31:0] pc_out;
  logic        ins_valid;
  logic        ins_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_controller #(.RESET_PC(32'd0), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_ins    (imem_ins),
    .ins_out     (ins_out),
    .pc_out      (pc_out),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  // Memory contents: tag in the upper half, word index (addr[9:0]) below.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {22'd0, a[9:0]};
  endfunction

  assign imem_ins = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    ins_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    halt        = 1'b0;
    #12;
    check("rst_valid",  {31'd0, ins_valid}, 32'd0);
    check("rst_addr",   imem_addr, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fcnt",   fetch_count, 32'd0);

    // Back-pressure: buffer fills to 2 and PC stalls at 2.
    rst = 1'b0;
    step();
    check("first_valid", {31'd0, ins_valid}, 32'd1);
    check("first_pc",    pc_out, 32'd0);
    check("first_addr",  imem_addr, 32'd1);
    for (int i = 0; i < 4; i++) step();
    check("full_addr", imem_addr, 32'd2);
    check("full_fcnt", fetch_count, 32'd2);
    check("full_ins",  ins_out, 32'hC0DE_0000);
    check("full_pc",   pc_out, 32'd0);

    // Stream with full buffer: simultaneous push/pop each cycle.
    ins_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("stream_pc",  pc_out, 32'(k));
      check("stream_ins", ins_out, mem_word(32'(k)));
      step();
    end
    check("stream_fcnt", fetch_count, 32'd8);
    check("stream_pc6",  pc_out, 32'd6);

    // Redirect on a full buffer with a pending pop.
    redirect    = 1'b1;
    redirect_pc = 32'd100;
    step();
    redirect = 1'b0;
    check("redir_valid", {31'd0, ins_valid}, 32'd0);
    check("redir_addr",  imem_addr, 32'd100);
    check("redir_fcnt",  fetch_count, 32'd8);
    step();
    check("redir_valid2", {31'd0, ins_valid}, 32'd1);
    check("redir_pc",     pc_out, 32'd100);
    check("redir_ins",    ins_out, 32'hC0DE_0064);
    ins_ready = 1'b0;
    step();
    check("refill_pc", pc_out, 32'd100);

    // Halt with two entries buffered; they drain, fetch stays stopped.
    halt = 1'b1;
    step();
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_pc",     pc_out, 32'd100);
    check("halt_addr",   imem_addr, 32'd102);
    ins_ready = 1'b1;
    step();
    check("drain_valid", {31'd0, ins_valid}, 32'd1);
    check("drain_pc",    pc_out, 32'd101);
    step();
    check("drained_valid", {31'd0, ins_valid}, 32'd0);
    halt = 1'b0;
    step();
    step();
    check("stay_halted", {31'd0, halted}, 32'd1);
    check("stay_valid",  {31'd0, ins_valid}, 32'd0);
    check("stay_addr",   imem_addr, 32'd102);
    check("stay_fcnt",   fetch_count, 32'd10);
    redirect    = 1'b1;
    redirect_pc = 32'd7;
    step();
    redirect = 1'b0;
    check("resume_halted", {31'd0, halted}, 32'd0);
    check("resume_valid",  {31'd0, ins_valid}, 32'd0);
    step();
    check("resume_pc",  pc_out, 32'd7);
    check("resume_ins", ins_out, 32'hC0DE_0007);

    // Address wrap of the 10-bit memory index.
    redirect    = 1'b1;
    redirect_pc = 32'd1022;
    step();
    redirect = 1'b0;
    step();
    check("wrap_pc0", pc_out, 32'd1022);
    check("wrap_ins0", ins_out, 32'hC0DE_03FE);
    step();
    check("wrap_pc1", pc_out, 32'd1023);
    step();
    check("wrap_pc2",  pc_out, 32'd1024);
    check("wrap_ins2", ins_out, 32'hC0DE_0000);

    // Asynchronous reset mid-stream, away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, ins_valid}, 32'd0);
    check("arst_addr",  imem_addr, 32'd0);
    check("arst_fcnt",  fetch_count, 32'd0);

    // From reset release with ins_ready high: one instruction per cycle.
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("run_valid", {31'd0, ins_valid}, 32'd1);
      check("run_pc",    pc_out, 32'(k));
      check("run_ins",   ins_out, mem_word(32'(k)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
